// File: rtl/boss_aggro.sv
// Per-player boss threat tracker: damage-driven aggro with frame-based decay and a
// hysteresis/lock-filtered target select feeding boss_move.
module boss_aggro #(
  parameter int AGGRO_MAX   = 15,
  parameter int DECAY_TICKS = 60,
  parameter int HYST        = 2,
  parameter int LOCK_TICKS  = 20
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       frame_tick,
  input  logic [1:0] game_active,
  input  logic       char_hit,
  input  logic [3:0] char_dmg,
  input  logic       player_2_hit,
  input  logic [3:0] player_2_dmg,
  output logic [3:0] char_aggro,
  output logic [3:0] player_2_aggro,
  output logic       aggro_target,
  output logic       target_changed
);

  localparam int DW = $clog2(DECAY_TICKS + 1);
  localparam int LW = $clog2(LOCK_TICKS + 1);

  typedef enum logic [1:0] {TGT_CHAR, PEND_P2, TGT_P2, PEND_CHAR} tgt_state_t;

  typedef struct packed {
    logic [3:0]    lvl;
    logic [DW-1:0] cnt;
  } aggro_t;

  function automatic logic [3:0] sat_add(input logic [3:0] a, input logic [3:0] d);
    logic [4:0] s;
    s = {1'b0, a} + {1'b0, d};
    if (s > 5'(AGGRO_MAX)) return 4'(AGGRO_MAX);
    return s[3:0];
  endfunction

  // A hit always wins over the frame tick; the counter parks at DECAY_TICKS once aggro is 0.
  function automatic aggro_t aggro_step(input aggro_t cur, input logic hit,
                                        input logic [3:0] dmg, input logic tick);
    aggro_t nxt;
    nxt = cur;
    if (hit) begin
      nxt.lvl = sat_add(cur.lvl, dmg);
      nxt.cnt = '0;
    end else if (tick && (cur.cnt != DW'(DECAY_TICKS))) begin
      if (cur.cnt == DW'(DECAY_TICKS - 1)) begin
        if (cur.lvl != 4'd0) begin
          nxt.lvl = cur.lvl - 4'd1;
          nxt.cnt = '0;
        end else begin
          nxt.cnt = DW'(DECAY_TICKS);
        end
      end else begin
        nxt.cnt = cur.cnt + DW'(1);
      end
    end
    return nxt;
  endfunction

  aggro_t        char_st, p2_st;
  tgt_state_t    state;
  logic [LW-1:0] lock_cnt;
  logic          p2_lead, char_lead;

  assign p2_lead   = {1'b0, p2_st.lvl}   >= ({1'b0, char_st.lvl} + 5'(HYST));
  assign char_lead = {1'b0, char_st.lvl} >= ({1'b0, p2_st.lvl}   + 5'(HYST));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      char_st        <= '0;
      p2_st          <= '0;
      state          <= TGT_CHAR;
      lock_cnt       <= '0;
      aggro_target   <= 1'b0;
      target_changed <= 1'b0;
    end else if (game_active == 2'd0) begin
      char_st        <= '0;
      p2_st          <= '0;
      state          <= TGT_CHAR;
      lock_cnt       <= '0;
      aggro_target   <= 1'b0;
      target_changed <= 1'b0;
    end else if (game_active[1]) begin
      target_changed <= 1'b0;
    end else begin
      char_st        <= aggro_step(char_st, char_hit, char_dmg, frame_tick);
      p2_st          <= aggro_step(p2_st, player_2_hit, player_2_dmg, frame_tick);
      target_changed <= 1'b0;
      if (frame_tick) begin
        case (state)
          TGT_CHAR: if (p2_lead) begin
            state    <= PEND_P2;
            lock_cnt <= LW'(1);
          end
          PEND_P2: if (!p2_lead) begin
            state    <= TGT_CHAR;
            lock_cnt <= '0;
          end else if (lock_cnt == LW'(LOCK_TICKS - 1)) begin
            state          <= TGT_P2;
            lock_cnt       <= '0;
            aggro_target   <= 1'b1;
            target_changed <= 1'b1;
          end else begin
            lock_cnt <= lock_cnt + LW'(1);
          end
          TGT_P2: if (char_lead) begin
            state    <= PEND_CHAR;
            lock_cnt <= LW'(1);
          end
          PEND_CHAR: if (!char_lead) begin
            state    <= TGT_P2;
            lock_cnt <= '0;
          end else if (lock_cnt == LW'(LOCK_TICKS - 1)) begin
            state          <= TGT_CHAR;
            lock_cnt       <= '0;
            aggro_target   <= 1'b0;
            target_changed <= 1'b1;
          end else begin
            lock_cnt <= lock_cnt + LW'(1);
          end
          default: begin
            state    <= TGT_CHAR;
            lock_cnt <= '0;
          end
        endcase
      end
    end
  end

  assign char_aggro     = char_st.lvl;
  assign player_2_aggro = p2_st.lvl;

endmodule

// File: tb/tb_boss_aggro.sv
// Scoreboard bench for boss_aggro: a behavioural model predicts every cycle's outputs.
module tb_boss_aggro;

  logic       clk, rst_n, frame_tick, char_hit, player_2_hit;
  logic [1:0] game_active;
  logic [3:0] char_dmg, player_2_dmg;
  logic [3:0] char_aggro, player_2_aggro;
  logic       aggro_target, target_changed;

  boss_aggro dut (
    .clk(clk), .rst_n(rst_n), .frame_tick(frame_tick), .game_active(game_active),
    .char_hit(char_hit), .char_dmg(char_dmg),
    .player_2_hit(player_2_hit), .player_2_dmg(player_2_dmg),
    .char_aggro(char_aggro), .player_2_aggro(player_2_aggro),
    .aggro_target(aggro_target), .target_changed(target_changed)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    int ca;
    int pa;
    int tgt;
    int chg;
  } exp_t;
  exp_t sbq[$];

  int n_chk = 0;
  int n_bad = 0;

  // model state: state 0=TGT_CHAR 1=PEND_P2 2=TGT_P2 3=PEND_CHAR
  int m_ca, m_pa, m_cc, m_pc, m_state, m_lock, m_tgt, m_chg;

  task automatic chk(input string tag, input int got, input int exp);
    n_chk++;
    if (got != exp) begin
      n_bad++;
      $display("FAIL %s got=%0d exp=%0d t=%0t", tag, got, exp, $time);
    end
  endtask

  task m_clear();
    m_ca = 0; m_pa = 0; m_cc = 0; m_pc = 0;
    m_state = 0; m_lock = 0; m_tgt = 0; m_chg = 0;
  endtask

  task automatic m_player(inout int lvl, inout int cnt, input bit hit, input int dmg,
                          input bit tick);
    if (hit) begin
      lvl = (lvl + dmg > 15) ? 15 : lvl + dmg;
      cnt = 0;
    end else if (tick) begin
      if (cnt < 60) cnt++;
      if (cnt == 60 && lvl > 0) begin
        lvl--;
        cnt = 0;
      end
    end
  endtask

  task m_step(input bit tick, input int ga, input bit ch, input int cd, input bit ph,
              input int pd);
    bit p2l, chl;
    if (ga == 0) begin
      m_clear();
    end else if (ga >= 2) begin
      m_chg = 0;
    end else begin
      m_chg = 0;
      if (tick) begin
        p2l = (m_pa >= m_ca + 2);
        chl = (m_ca >= m_pa + 2);
        case (m_state)
          0: if (p2l) begin m_state = 1; m_lock = 1; end
          1: if (p2l) begin
               m_lock++;
               if (m_lock == 20) begin m_state = 2; m_lock = 0; m_tgt = 1; m_chg = 1; end
             end else begin m_state = 0; m_lock = 0; end
          2: if (chl) begin m_state = 3; m_lock = 1; end
          default: if (chl) begin
               m_lock++;
               if (m_lock == 20) begin m_state = 0; m_lock = 0; m_tgt = 0; m_chg = 1; end
             end else begin m_state = 2; m_lock = 0; end
        endcase
      end
      m_player(m_ca, m_cc, ch, cd, tick);
      m_player(m_pa, m_pc, ph, pd, tick);
    end
  endtask

  // Drive one cycle, predict, then compare after the edge.
  task cyc(input bit tick, input int ga, input bit ch, input int cd, input bit ph,
           input int pd);
    exp_t e;
    frame_tick   = tick;
    game_active  = 2'(ga);
    char_hit     = ch;
    char_dmg     = 4'(cd);
    player_2_hit = ph;
    player_2_dmg = 4'(pd);
    m_step(tick, ga, ch, cd, ph, pd);
    sbq.push_back('{m_ca, m_pa, m_tgt, m_chg});
    @(posedge clk);
    #1;
    if (sbq.size() == 0) begin
      chk("sb_underflow", 0, 1);
    end else begin
      e = sbq.pop_front();
      chk("char_aggro", int'(char_aggro), e.ca);
      chk("p2_aggro", int'(player_2_aggro), e.pa);
      chk("aggro_target", int'(aggro_target), e.tgt);
      chk("target_changed", int'(target_changed), e.chg);
    end
  endtask

  task ticks(input int n);
    for (int i = 0; i < n; i++) begin
      cyc(1, 1, 0, 0, 0, 0);
      cyc(0, 1, 0, 0, 0, 0);
    end
  endtask

  task do_async_reset();
    #2 rst_n = 1'b0;
    m_clear();
    #1;
    chk("rst_char", int'(char_aggro), 0);
    chk("rst_p2", int'(player_2_aggro), 0);
    chk("rst_tgt", int'(aggro_target), 0);
    chk("rst_chg", int'(target_changed), 0);
    @(posedge clk);
    #1 rst_n = 1'b1;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    rst_n = 1'b0; frame_tick = 1'b0; game_active = 2'd0;
    char_hit = 1'b0; char_dmg = 4'd0; player_2_hit = 1'b0; player_2_dmg = 4'd0;
    m_clear();
    #1;
    chk("init_char", int'(char_aggro), 0);
    chk("init_p2", int'(player_2_aggro), 0);
    chk("init_tgt", int'(aggro_target), 0);
    chk("init_chg", int'(target_changed), 0);
    @(posedge clk);
    #1 rst_n = 1'b1;

    // saturation
    cyc(0, 1, 0, 0, 0, 0);
    cyc(0, 1, 1, 12, 0, 0);
    chk("sat_load12", int'(char_aggro), 12);
    cyc(0, 1, 1, 7, 0, 0);
    chk("sat_to15", int'(char_aggro), 15);
    cyc(0, 1, 1, 15, 0, 0);
    chk("sat_stay15", int'(char_aggro), 15);

    // decay 3 -> 2 -> 0, then parked without wrap
    cyc(0, 0, 0, 0, 0, 0);
    cyc(0, 1, 0, 0, 1, 3);
    ticks(59);
    chk("decay_59", int'(player_2_aggro), 3);
    ticks(1);
    chk("decay_60", int'(player_2_aggro), 2);
    ticks(120);
    chk("decay_180", int'(player_2_aggro), 0);
    ticks(70);
    chk("decay_park", int'(player_2_aggro), 0);
    cyc(0, 1, 0, 0, 1, 1);
    ticks(59);
    chk("decay_nowrap59", int'(player_2_aggro), 1);
    ticks(1);
    chk("decay_nowrap60", int'(player_2_aggro), 0);

    // zero-damage hit restarts the decay counter
    cyc(0, 0, 0, 0, 0, 0);
    cyc(0, 1, 0, 0, 1, 2);
    ticks(30);
    cyc(0, 1, 0, 0, 1, 0);
    ticks(59);
    chk("dmg0_hold", int'(player_2_aggro), 2);
    ticks(1);
    chk("dmg0_decay", int'(player_2_aggro), 1);

    // hit on the decay frame wins
    cyc(0, 0, 0, 0, 0, 0);
    cyc(0, 1, 0, 0, 1, 3);
    ticks(59);
    cyc(1, 1, 0, 0, 1, 2);
    chk("hit_on_decay", int'(player_2_aggro), 5);
    ticks(59);
    chk("hit_restart59", int'(player_2_aggro), 5);
    ticks(1);
    chk("hit_restart60", int'(player_2_aggro), 4);

    // switch to p2 after 20 ticks, then back to char
    cyc(0, 0, 0, 0, 0, 0);
    cyc(0, 1, 1, 4, 1, 6);
    ticks(19);
    chk("sw_pend_tgt", int'(aggro_target), 0);
    cyc(1, 1, 0, 0, 0, 0);
    chk("sw_tgt", int'(aggro_target), 1);
    chk("sw_pulse", int'(target_changed), 1);
    cyc(0, 1, 0, 0, 0, 0);
    chk("sw_pulse_end", int'(target_changed), 0);
    cyc(0, 1, 1, 4, 0, 0);
    ticks(19);
    chk("swb_pend_tgt", int'(aggro_target), 1);
    cyc(1, 1, 0, 0, 0, 0);
    chk("swb_tgt", int'(aggro_target), 0);
    chk("swb_pulse", int'(target_changed), 1);

    // margin lost at frame 10 aborts without a pulse
    cyc(0, 0, 0, 0, 0, 0);
    cyc(0, 1, 1, 4, 1, 6);
    ticks(9);
    cyc(0, 1, 1, 1, 0, 0);
    cyc(1, 1, 0, 0, 0, 0);
    chk("abort_chg", int'(target_changed), 0);
    ticks(25);
    chk("abort_tgt", int'(aggro_target), 0);

    // hold freezes, clear wipes
    cyc(0, 0, 0, 0, 0, 0);
    cyc(0, 1, 1, 5, 0, 0);
    for (int i = 0; i < 6; i++) cyc(1, (i % 2) ? 3 : 2, 1, 3, 1, 3);
    chk("hold_char", int'(char_aggro), 5);
    chk("hold_p2", int'(player_2_aggro), 0);
    cyc(1, 0, 1, 5, 1, 5);
    chk("clear_char", int'(char_aggro), 0);

    // async reset while in PEND_P2 with char=9
    cyc(0, 1, 1, 9, 1, 11);
    ticks(1);
    chk("pre_rst_char", int'(char_aggro), 9);
    do_async_reset();
    cyc(0, 1, 0, 0, 1, 3);
    ticks(19);
    chk("post_rst_tgt19", int'(aggro_target), 0);
    ticks(1);
    chk("post_rst_tgt20", int'(aggro_target), 1);

    // random traffic against the model
    for (int i = 0; i < 600; i++) begin
      int r, ga;
      r  = int'($urandom_range(0, 31));
      ga = (r == 0) ? 0 : (r == 1) ? 2 : (r == 2) ? 3 : 1;
      cyc($urandom_range(0, 2) == 0, ga,
          $urandom_range(0, 9) == 0, int'($urandom_range(0, 15)),
          $urandom_range(0, 7) == 0, int'($urandom_range(0, 15)));
    end

    $display("test done: total=%0d bad=%0d", n_chk, n_bad);
    $finish;
  end

endmodule
